multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences the shared datapath (one ALU, one unified memory port, register file, PC/IR registers) through FETCH/DECODE/EXECUTE/MEM/WB for R, I-ALU, LOAD, STORE and BRANCH opcodes. It drives a req/ready handshake to memory with a wait timeout. It raises a sticky trap on an illegal opcode or a memory timeout.

---
 rtl/multicycle_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB with memory timeout trap.
// Optional perf counters enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [6:0]  opcode_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_sel_instr_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic        branch_o,
    output logic        reg_write_o,
    output logic        mem_to_reg_o,
    output logic [2:0]  state_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_o
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH
    } cls_t;

    state_t            state;
    cls_t              cls;
    cls_t              dec_cls;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        cause;
    logic              timeout_hit;

    always_comb begin
        dec_cls = C_NONE;
        unique case (1'b1)
            (opcode_i == 7'b0110011): dec_cls = C_R;
            (opcode_i == 7'b0010011): dec_cls = C_I;
            (opcode_i == 7'b0000011): dec_cls = C_LOAD;
            (opcode_i == 7'b0100011): dec_cls = C_STORE;
            (opcode_i == 7'b1100011): dec_cls = C_BRANCH;
            default:                  dec_cls = C_NONE;
        endcase
    end

    // The final unanswered request cycle traps; ready in that cycle still wins.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST) && !mem_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= S_FETCH;
            cls      <= C_NONE;
            wait_cnt <= '0;
            cause    <= 2'd0;
        end else begin
            wait_cnt <= '0;
            unique case (state)
                S_FETCH: begin
                    if (mem_ready_i) begin
                        state <= S_DECODE;
                    end else if (timeout_hit) begin
                        state <= S_TRAP;
                        cause <= 2'd2;
                    end else begin
                        wait_cnt <= (wait_cnt != WAIT_MAX) ? wait_cnt + 1'b1 : wait_cnt;
                    end
                end
                S_DECODE: begin
                    cls <= dec_cls;
                    if (dec_cls == C_NONE) begin
                        state <= S_TRAP;
                        cause <= 2'd1;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    unique case (cls)
                        C_R, C_I:        state <= S_WB;
                        C_LOAD, C_STORE: state <= S_MEM;
                        default:         state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready_i) begin
                        state <= (cls == C_STORE) ? S_FETCH : S_WB;
                    end else if (timeout_hit) begin
                        state <= S_TRAP;
                        cause <= 2'd3;
                    end else begin
                        wait_cnt <= (wait_cnt != WAIT_MAX) ? wait_cnt + 1'b1 : wait_cnt;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_sel_instr_o = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        alu_src_a_o     = 2'd0;
        alu_src_b_o     = 2'd0;
        alu_op_o        = 2'd0;
        branch_o        = 1'b0;
        reg_write_o     = 1'b0;
        mem_to_reg_o    = 1'b0;
        if (rst_ni) begin
            unique case (state)
                S_FETCH: begin
                    mem_req_o       = 1'b1;
                    mem_sel_instr_o = 1'b1;
                    alu_src_b_o     = 2'd1;
                    ir_write_o      = mem_ready_i;
                    pc_write_o      = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_a_o = 2'd2;
                    alu_src_b_o = 2'd2;
                end
                S_EXECUTE: begin
                    alu_src_a_o = 2'd1;
                    unique case (cls)
                        C_R: alu_op_o = 2'd2;
                        C_I: begin
                            alu_src_b_o = 2'd2;
                            alu_op_o    = 2'd2;
                        end
                        C_LOAD, C_STORE: alu_src_b_o = 2'd2;
                        C_BRANCH: begin
                            alu_op_o = 2'd1;
                            branch_o = 1'b1;
                        end
                        default: alu_op_o = 2'd0;
                    endcase
                end
                S_MEM: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = (cls == C_STORE);
                end
                S_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = (cls == C_LOAD);
                end
                default: mem_req_o = 1'b0;
            endcase
        end
    end

    assign state_o      = rst_ni ? state : 3'd0;
    assign trap_o       = rst_ni && (state == S_TRAP);
    assign trap_cause_o = rst_ni ? cause : 2'd0;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret;
    logic        retire;

    assign retire = (state == S_WB)
                 || (state == S_MEM && cls == C_STORE && mem_ready_i)
                 || (state == S_EXECUTE && cls == C_BRANCH);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (state != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
            if (retire)          instret   <= instret + 32'd1;
        end
    end

    assign cycle_cnt_o = rst_ni ? cycle_cnt : '0;
    assign instret_o   = rst_ni ? instret : '0;
`else
    assign cycle_cnt_o = '0;
    assign instret_o   = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized + directed bench for multicycle_ctrl against a phase-queue model.
// Counter expectations follow MULTICYCLE_CTRL_PERF_EN.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [6:0]  opcode_i = '0;
    logic        mem_ready_i = 1'b0;
    logic        mem_req_o, mem_we_o, mem_sel_instr_o, ir_write_o, pc_write_o;
    logic [1:0]  alu_src_a_o, alu_src_b_o, alu_op_o;
    logic        branch_o, reg_write_o, mem_to_reg_o;
    logic [2:0]  state_o;
    logic        trap_o;
    logic [1:0]  trap_cause_o;
    logic [31:0] cycle_cnt_o, instret_o;

    multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i),
        .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_sel_instr_o(mem_sel_instr_o), .ir_write_o(ir_write_o),
        .pc_write_o(pc_write_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .branch_o(branch_o),
        .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
        .state_o(state_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o),
        .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef struct {
        int st;
        bit req, we, sel;
        int a, b, op;
        bit br, rw, mtr, ret;
    } ph_t;

    ph_t         q[$];
    bit          m_trap;
    int          m_cause;
    int          m_wait;
    logic [31:0] m_cyc, m_ins;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [2:0]  s_state;
    logic        s_req, s_we, s_sel, s_br, s_rw, s_mtr, s_trap;
    logic [1:0]  s_op, s_cause;
    logic [31:0] s_cyc, s_ins;

    function automatic ph_t mk(int st, bit req, bit we, bit sel, int a, int b,
                               int op, bit br, bit rw, bit mtr, bit ret);
        ph_t p;
        p.st = st; p.req = req; p.we = we; p.sel = sel;
        p.a = a; p.b = b; p.op = op;
        p.br = br; p.rw = rw; p.mtr = mtr; p.ret = ret;
        return p;
    endfunction

    function automatic logic [19:0] pack(bit req, bit we, bit sel, bit irw, bit pcw,
                                         int a, int b, int op, bit br, bit rw,
                                         bit mtr, int st, bit trap, int cause);
        return {req, we, sel, irw, pcw, 2'(a), 2'(b), 2'(op), br, rw, mtr,
                3'(st), trap, 2'(cause)};
    endfunction

    function void new_instr();
        q.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0));
    endfunction

    function void advance();
        if (q[0].ret) m_ins = m_ins + 32'd1;
        void'(q.pop_front());
        m_wait = 0;
        if (q.size() == 0) new_instr();
    endfunction

    function void model_step(logic r, logic [6:0] o, logic rd);
        if (!r) begin
            q.delete();
            new_instr();
            m_trap = 0; m_cause = 0; m_wait = 0;
            m_cyc = 0; m_ins = 0;
        end else if (!m_trap) begin
            m_cyc = m_cyc + 32'd1;
            if (q[0].req) begin
                if (rd) advance();
                else if (TO > 0 && m_wait + 1 == TO) begin
                    m_trap = 1;
                    m_cause = (q[0].st == 0) ? 2 : 3;
                end else m_wait++;
            end else if (q[0].st == 1) begin
                void'(q.pop_front());
                case (o)
                    OP_R: begin
                        q.push_back(mk(2, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0));
                        q.push_back(mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
                    end
                    OP_I: begin
                        q.push_back(mk(2, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0));
                        q.push_back(mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
                    end
                    OP_LD: begin
                        q.push_back(mk(2, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
                        q.push_back(mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                        q.push_back(mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
                    end
                    OP_ST: begin
                        q.push_back(mk(2, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
                        q.push_back(mk(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
                    end
                    OP_BR: q.push_back(mk(2, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1));
                    default: begin
                        m_trap = 1;
                        m_cause = 1;
                        new_instr();
                    end
                endcase
                m_wait = 0;
            end else advance();
        end
    endfunction

    task automatic check(input logic r, input logic rd);
        logic [19:0] ev, av;
        logic [31:0] ec, ei;
        bit f;
        if (!r) ev = '0;
        else if (m_trap) ev = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, m_cause);
        else begin
            f = (q[0].st == 0) && rd;
            ev = pack(q[0].req, q[0].we, q[0].sel, f, f, q[0].a, q[0].b, q[0].op,
                      q[0].br, q[0].rw, q[0].mtr, q[0].st, 0, 0);
        end
        av = {mem_req_o, mem_we_o, mem_sel_instr_o, ir_write_o, pc_write_o,
              alu_src_a_o, alu_src_b_o, alu_op_o, branch_o, reg_write_o,
              mem_to_reg_o, state_o, trap_o, trap_cause_o};
        ec = (r && PERF) ? m_cyc : 32'd0;
        ei = (r && PERF) ? m_ins : 32'd0;
        n_checks++;
        if (av !== ev) begin
            n_fail++;
            $display("FAIL outputs t=%0t actual=%h expected=%h", $time, av, ev);
        end
        n_checks++;
        if (cycle_cnt_o !== ec) begin
            n_fail++;
            $display("FAIL cycle_cnt t=%0t actual=%0d expected=%0d", $time, cycle_cnt_o, ec);
        end
        n_checks++;
        if (instret_o !== ei) begin
            n_fail++;
            $display("FAIL instret t=%0t actual=%0d expected=%0d", $time, instret_o, ei);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [6:0] o, input logic rd);
        rst_ni = r; opcode_i = o; mem_ready_i = rd;
        #1;
        check(r, rd);
        s_state = state_o; s_req = mem_req_o; s_we = mem_we_o; s_sel = mem_sel_instr_o;
        s_br = branch_o; s_rw = reg_write_o; s_mtr = mem_to_reg_o; s_trap = trap_o;
        s_op = alu_op_o; s_cause = trap_cause_o; s_cyc = cycle_cnt_o; s_ins = instret_o;
        model_step(r, o, rd);
        @(posedge clk_i);
        #1;
    endtask

    logic [6:0] legal [5];
    int thr [4];

    initial begin
        int n, k, sts[5];
        logic r, rd;
        logic [6:0] o;
        legal = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR};
        thr = '{9, 5, 2, 10};

        cyc(0, OP_R, 1);
        lit("reset_state", int'(s_state), 0);
        lit("reset_req", int'(s_req), 0);
        cyc(0, OP_R, 1);

        // R-type, zero-wait memory
        for (int i = 0; i < 5; i++) begin
            cyc(1, OP_R, 1);
            sts[i] = int'(s_state);
            if (i == 2) lit("r_alu_op", int'(s_op), 2);
            if (i == 3) lit("r_wb", int'({s_rw, s_mtr}), 2);
        end
        lit("r_seq", sts[0] * 10000 + sts[1] * 1000 + sts[2] * 100 + sts[3] * 10 + sts[4], 1240);

        // LOAD with three wait cycles
        cyc(0, OP_R, 1);
        n = 0; k = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, OP_LD, (i >= 3 && i <= 5) ? 1'b0 : 1'b1);
            if (s_req && !s_sel) n++;
            if (s_state != 0 || i == 0) k++;
            if (i == 7) lit("ld_wb_mtr", int'(s_mtr), 1);
        end
        lit("ld_mem_cycles", n, 4);
        lit("ld_total", k, 8);
        cyc(1, OP_R, 1);
        lit("ld_back_fetch", int'(s_state), 0);
        lit("ld_instret", int'(s_ins), PERF ? 1 : 0);

        // STORE then BRANCH
        cyc(0, OP_R, 1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, OP_ST, 1);
            if (s_we) n = n + 1 + 10 * int'(s_state);
        end
        lit("st_we", n, 31);
        cyc(1, OP_BR, 1);
        lit("st_retired_fetch", int'(s_state), 0);
        cyc(1, OP_BR, 1);
        cyc(1, OP_BR, 1);
        lit("br_exec", int'({s_state, s_br, s_op}), 'b010_1_01);
        cyc(1, OP_R, 1);
        lit("br_fetch", int'(s_state), 0);

        // illegal opcode trap, held then cleared by reset
        cyc(0, OP_R, 1);
        cyc(1, 7'h7F, 1);
        cyc(1, 7'h7F, 1);
        for (int i = 0; i < 12; i++) cyc(1, 7'($urandom), 1'($urandom));
        lit("ill_trap", int'({s_state, s_trap, s_cause}), 'b101_1_01);
        cyc(0, OP_R, 1);
        lit("ill_reset", int'({s_state, s_trap}), 0);
        cyc(1, OP_R, 0);
        lit("ill_refetch", int'({s_state, s_sel}), 1);

        // fetch timeout: exactly TO unanswered cycles
        cyc(0, OP_R, 1);
        n = 0; k = 0;
        while (k < 20) begin
            cyc(1, OP_R, 0);
            if (s_req) n++;
            k++;
            if (s_state == 5) break;
        end
        lit("to_cycles", n, 4);
        lit("to_cause", int'({s_trap, s_cause}), 'b1_10);
        cyc(0, OP_R, 1);
        for (int i = 0; i < 3; i++) cyc(1, OP_R, 0);
        cyc(1, OP_R, 1);
        cyc(1, OP_R, 1);
        lit("to_ready_last", int'(s_state), 1);

        // reset asserted mid-MEM
        cyc(0, OP_R, 1);
        cyc(1, OP_LD, 1);
        cyc(1, OP_LD, 1);
        cyc(1, OP_LD, 1);
        cyc(1, OP_LD, 0);
        lit("mem_req_before", int'({s_state, s_req, s_sel}), 'b011_1_0);
        cyc(0, OP_LD, 0);
        lit("mem_rst_zero", int'({s_state, s_req, s_sel, s_rw}), 0);
        cyc(1, OP_R, 0);
        lit("mem_rst_fetch", int'({s_state, s_sel}), 1);
        lit("mem_rst_cyc0", int'(s_cyc), 0);
        cyc(1, OP_R, 0);
        lit("mem_rst_cyc1", int'(s_cyc), PERF ? 1 : 0);

        // randomized traffic
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 1000; i++) begin
                r = m_trap ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 299) != 0);
                o = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal[$urandom_range(0, 4)];
                rd = ($urandom_range(0, 9) < thr[seg]);
                cyc(r, o, rd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
